// File: rtl/alu_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
package alu_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    ADC = 2'd2,
    SBB = 2'd3
  } addsub_op_e;

  typedef struct packed {
    logic cf;
    logic of;
    logic zf;
    logic nf;
  } flags_t;

  function automatic logic is_sub(addsub_op_e op);
    return (op == SUB) || (op == SBB);
  endfunction

  // Carry into bit 0: SBB borrow-in becomes an inverted carry-in.
  function automatic logic carry_in(addsub_op_e op, logic cf);
    case (op)
      ADD:     return 1'b0;
      SUB:     return 1'b1;
      ADC:     return cf;
      default: return ~cf;
    endcase
  endfunction

endpackage

// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle between the execute stage and the add/sub pipe.
interface addsub_pipe_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  addsub_op_e       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cf;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_cf;
  logic             out_of;
  logic             out_zf;
  logic             out_nf;

  modport master (
    output in_valid, in_op, in_a, in_b, in_cf, out_ready,
    input  in_ready, out_valid, out_result, out_cf, out_of, out_zf, out_nf
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_cf, out_ready,
    output in_ready, out_valid, out_result, out_cf, out_of, out_zf, out_nf
  );
endinterface

// File: rtl/addsub_seg.sv
// Combinational SEG_WIDTH-bit adder slice; also exposes the carry into its MSB.
module addsub_seg #(
  parameter int unsigned SEG_WIDTH = 8
) (
  input  logic [SEG_WIDTH-1:0] a,
  input  logic [SEG_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [SEG_WIDTH-1:0] sum,
  output logic                 cout,
  output logic                 c_msb_in
);
  localparam int unsigned EXT_W = SEG_WIDTH + 1;

  logic [SEG_WIDTH:0] full;

  assign full = {1'b0, a} + {1'b0, b} + EXT_W'(cin);
  assign sum  = full[SEG_WIDTH-1:0];
  assign cout = full[SEG_WIDTH];
  // Carry into the top bit recovered from its sum: s = a ^ b ^ c.
  assign c_msb_in = a[SEG_WIDTH-1] ^ b[SEG_WIDTH-1] ^ sum[SEG_WIDTH-1];
endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement add/subtract, one carry segment resolved per stage,
// with carry/borrow chaining, status flags and valid/ready backpressure.
module addsub_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SEG_WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  addsub_pipe_if.slave bus
);
  localparam int unsigned NUM_SEG = (SEG_WIDTH == 0) ? 1 : WIDTH / SEG_WIDTH;

  if (SEG_WIDTH < 1 || (WIDTH % ((SEG_WIDTH == 0) ? 1 : SEG_WIDTH)) != 0) begin : g_bad_param
    $error("addsub_pipe: WIDTH must be a multiple of SEG_WIDTH and SEG_WIDTH >= 1");
  end

  logic             en;
  logic             out_valid;
  logic [WIDTH-1:0] b_in;
  logic             cin0;

  assign out_valid    = g_stg[NUM_SEG-1].valid_q;
  assign en           = ~out_valid | bus.out_ready;
  assign bus.in_ready = en;
  assign b_in         = is_sub(bus.in_op) ? ~bus.in_b : bus.in_b;
  assign cin0         = carry_in(bus.in_op, bus.in_cf);

  // Stage k resolves segment k; unresolved A/B' segments shrink by one per stage.
  for (genvar k = 0; k < NUM_SEG; k++) begin : g_stg
    localparam int unsigned SRC  = WIDTH - k * SEG_WIDTH;
    localparam int unsigned DONE = (k + 1) * SEG_WIDTH;

    logic [SRC-1:0]       a_src;
    logic [SRC-1:0]       b_src;
    logic [DONE-1:0]      sum_d;
    logic [DONE-1:0]      sum_q;
    logic [SEG_WIDTH-1:0] s_seg;
    logic                 cin;
    logic                 cout;
    logic                 c_msb;
    logic                 valid_d;
    logic                 valid_q;
    addsub_op_e           op_d;

    if (k == 0) begin : g_src
      assign a_src   = bus.in_a;
      assign b_src   = b_in;
      assign cin     = cin0;
      assign valid_d = bus.in_valid;
      assign op_d    = bus.in_op;
      assign sum_d   = s_seg;
    end else begin : g_src
      assign a_src   = g_stg[k-1].g_rem.a_q;
      assign b_src   = g_stg[k-1].g_rem.b_q;
      assign cin     = g_stg[k-1].g_rem.carry_q;
      assign valid_d = g_stg[k-1].valid_q;
      assign op_d    = g_stg[k-1].g_rem.op_q;
      assign sum_d   = {s_seg, g_stg[k-1].sum_q};
    end

    addsub_seg #(.SEG_WIDTH(SEG_WIDTH)) u_seg (
      .a        (a_src[SEG_WIDTH-1:0]),
      .b        (b_src[SEG_WIDTH-1:0]),
      .cin      (cin),
      .sum      (s_seg),
      .cout     (cout),
      .c_msb_in (c_msb)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
      end else if (en) begin
        valid_q <= valid_d;
      end
    end

    // Data moves with en regardless of valid; bubbles advance unchanged.
    always_ff @(posedge clk) begin
      if (en) begin
        sum_q <= sum_d;
      end
    end

    if (k < NUM_SEG - 1) begin : g_rem
      logic [SRC-SEG_WIDTH-1:0] a_q;
      logic [SRC-SEG_WIDTH-1:0] b_q;
      logic                     carry_q;
      addsub_op_e               op_q;
      logic                     unused_c_msb;

      assign unused_c_msb = c_msb;

      always_ff @(posedge clk) begin
        if (en) begin
          a_q     <= a_src[SRC-1:SEG_WIDTH];
          b_q     <= b_src[SRC-1:SEG_WIDTH];
          carry_q <= cout;
          op_q    <= op_d;
        end
      end
    end else begin : g_last
      flags_t flags_d;
      flags_t flags_q;

      always_comb begin
        flags_d    = '0;
        flags_d.cf = cout ^ is_sub(op_d);
        flags_d.of = cout ^ c_msb;
        flags_d.zf = ~|sum_d;
        flags_d.nf = sum_d[DONE-1];
      end

      always_ff @(posedge clk) begin
        if (en) begin
          flags_q <= flags_d;
        end
      end
    end
  end

  // Outputs read zero whenever no result is presented.
  assign bus.out_valid  = out_valid;
  assign bus.out_result = out_valid ? g_stg[NUM_SEG-1].sum_q : '0;
  assign bus.out_cf     = out_valid & g_stg[NUM_SEG-1].g_last.flags_q.cf;
  assign bus.out_of     = out_valid & g_stg[NUM_SEG-1].g_last.flags_q.of;
  assign bus.out_zf     = out_valid & g_stg[NUM_SEG-1].g_last.flags_q.zf;
  assign bus.out_nf     = out_valid & g_stg[NUM_SEG-1].g_last.flags_q.nf;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe (WIDTH=32, SEG_WIDTH=8, latency 4).
module tb_addsub_pipe;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  addsub_pipe_if #(.WIDTH(32)) bus ();

  addsub_pipe #(.WIDTH(32), .SEG_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] flags_obs();
    return {bus.out_cf, bus.out_of, bus.out_zf, bus.out_nf};
  endfunction

  // One isolated op: exact 4-cycle latency, result/flags, single emission.
  task automatic run_op(input string tag, input addsub_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic cf, input logic [31:0] er,
                        input logic [3:0] ef);
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'(1));
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cf    = cf;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("%s early valid c%0d", tag, i), 64'(bus.out_valid), 64'(0));
      tick();
    end
    chk({tag, " valid"}, 64'(bus.out_valid), 64'(1));
    chk({tag, " result"}, 64'(bus.out_result), 64'(er));
    chk({tag, " flags cf/of/zf/nf"}, 64'(flags_obs()), 64'(ef));
    tick();
    chk({tag, " drained"}, 64'(bus.out_valid), 64'(0));
  endtask

  addsub_op_e  s_op  [8] = '{ADD, SUB, ADD, SUB, ADD, SUB, ADD, SUB};
  logic [31:0] s_a   [8] = '{32'h1, 32'hA, 32'h0000FFFF, 32'h0,
                             32'h12345678, 32'h1000, 32'h00FF00FF, 32'h80000000};
  logic [31:0] s_b   [8] = '{32'h2, 32'h4, 32'h1, 32'h1,
                             32'h11111111, 32'h1, 32'h00010001, 32'h80000000};
  logic [31:0] s_exp [8] = '{32'h3, 32'h6, 32'h00010000, 32'hFFFFFFFF,
                             32'h23456789, 32'hFFF, 32'h01000100, 32'h0};

  initial begin
    int          sent;
    int          recv;
    int          stalls;
    logic        held_v;
    logic [31:0] held;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = ADD;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cf     = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("in reset out_valid", 64'(bus.out_valid), 64'(0));
    rst = 1'b0;
    chk("post reset in_ready", 64'(bus.in_ready), 64'(1));
    chk("post reset result", 64'(bus.out_result), 64'(0));
    chk("post reset flags", 64'(flags_obs()), 64'(0));

    // flags are {cf, of, zf, nf}
    run_op("sub 5-3",      SUB, 32'h5,        32'h3,        1'b0, 32'h00000002, 4'b0000);
    run_op("sub 3-5",      SUB, 32'h3,        32'h5,        1'b0, 32'hFFFFFFFE, 4'b1001);
    run_op("add ovf",      ADD, 32'h7FFFFFFF, 32'h1,        1'b0, 32'h80000000, 4'b0101);
    run_op("add wrap",     ADD, 32'hFFFFFFFF, 32'h1,        1'b0, 32'h00000000, 4'b1010);
    run_op("adc seg",      ADC, 32'h000000FF, 32'h0,        1'b1, 32'h00000100, 4'b0000);
    run_op("sbb 0-0-1",    SBB, 32'h0,        32'h0,        1'b1, 32'hFFFFFFFF, 4'b1001);
    run_op("sub neg ovf",  SUB, 32'h80000000, 32'h1,        1'b0, 32'h7FFFFFFF, 4'b0100);
    run_op("add cf ign",   ADD, 32'h1,        32'h1,        1'b1, 32'h00000002, 4'b0000);
    run_op("sbb seg",      SBB, 32'h00000100, 32'h0,        1'b1, 32'h000000FF, 4'b0000);
    run_op("adc cf0",      ADC, 32'hFFFF0000, 32'h0000FFFF, 1'b0, 32'hFFFFFFFF, 4'b0001);

    // Back-to-back stream with out_ready low on cycles 6..9.
    sent   = 0;
    recv   = 0;
    stalls = 0;
    held_v = 1'b0;
    held   = '0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      bus.out_ready = !(cyc >= 6 && cyc <= 9);
      bus.in_valid  = (sent < 8);
      bus.in_cf     = 1'b0;
      if (sent < 8) begin
        bus.in_op = s_op[sent];
        bus.in_a  = s_a[sent];
        bus.in_b  = s_b[sent];
      end
      #1;
      if (held_v) chk("stream hold stable", 64'(bus.out_result), 64'(held));
      held_v = 1'b0;
      if (bus.out_valid && !bus.out_ready) begin
        stalls++;
        chk($sformatf("stream in_ready low c%0d", cyc), 64'(bus.in_ready), 64'(0));
        held   = bus.out_result;
        held_v = 1'b1;
      end else begin
        chk($sformatf("stream in_ready high c%0d", cyc), 64'(bus.in_ready), 64'(1));
      end
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("stream res%0d", recv), 64'(bus.out_result), 64'(s_exp[recv]));
        recv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream sent", 64'(sent), 64'(8));
    chk("stream received", 64'(recv), 64'(8));
    chk("stream stall cycles", 64'(stalls), 64'(4));
    chk("stream no duplicate", 64'(bus.out_valid), 64'(0));
    tick();
    chk("stream empty", 64'(bus.out_valid), 64'(0));

    // Reset with three ops in flight.
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_op    = ADD;
      bus.in_a     = 32'(i + 1);
      bus.in_b     = 32'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid rst out_valid", 64'(bus.out_valid), 64'(0));
    chk("mid rst in_ready", 64'(bus.in_ready), 64'(1));
    chk("mid rst result", 64'(bus.out_result), 64'(0));
    chk("mid rst flags", 64'(flags_obs()), 64'(0));
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("no stale c%0d", i), 64'(bus.out_valid), 64'(0));
      tick();
    end
    run_op("after rst", ADD, 32'h0F0F0F0F, 32'h01010101, 1'b0, 32'h10101010, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
